// File: rtl/qcl_differentiator_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qcl_differentiator_pkg: shared types and helpers for qcl_differentiator  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package qcl_differentiator_pkg;

  typedef enum logic [0:0] {
    e_diff_empty  = 1'b0,
    e_diff_primed = 1'b1
  } diff_state_e;

  // Signed overflow of a - b: operands of opposite sign and the result sign flipped away from a.
  function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage
`default_nettype wire

// File: rtl/qcl_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qcl_add_sub: width-generic adder/subtractor with optional output pipe    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qcl_add_sub #(
  parameter int width_p          = 8,
  parameter int is_add_not_sub_p = 1,
  parameter int latency_p        = 0,
  parameter int harden_p         = 0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic [width_p-1:0] o
);

  logic [width_p-1:0] w_result;
  logic               unused_harden;

  assign w_result      = (is_add_not_sub_p != 0) ? (a_i + b_i) : (a_i - b_i);
  // Hardening selects a vendor macro on ASIC flows; the generic build is plain logic.
  assign unused_harden = ^harden_p;

  if (latency_p == 0) begin : g_comb
    logic unused_clk;
    assign unused_clk = clk_i ^ reset_ni;
    assign o = w_result;
  end else begin : g_pipe
    logic [width_p-1:0] r_pipe [latency_p];
    always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
        for (int i = 0; i < latency_p; i++) r_pipe[i] <= '0;
      end else begin
        r_pipe[0] <= w_result;
        for (int i = 1; i < latency_p; i++) r_pipe[i] <= r_pipe[i-1];
      end
    end
    assign o = r_pipe[latency_p-1];
  end

endmodule
`default_nettype wire

// File: rtl/qcl_differentiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | qcl_differentiator: streaming first difference, inverse of the running   |
// | sum accumulator. QCL_DIFFERENTIATOR_OVF_EN adds a signed overflow flag.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module qcl_differentiator
  import qcl_differentiator_pkg::*;
#(
  parameter int width_p  = 8,
  parameter int harden_p = 0
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] diff_o,
  output logic               first_o,
`ifdef QCL_DIFFERENTIATOR_OVF_EN
  output logic               ovf_o,
`endif
  input  logic               yumi_i
);

  diff_state_e        r_state, w_state_next;
  logic [width_p-1:0] r_prev;
  logic [width_p-1:0] w_prev_used;
  logic [width_p-1:0] w_diff;
  logic               w_accept;
  logic               w_first;

  assign ready_o  = ~v_o | yumi_i;
  assign w_accept = v_i & ready_o;

  // A clear in the same cycle as an accept restarts the stream at that very sample.
  assign w_prev_used = clear_i ? '0 : r_prev;
  assign w_first     = clear_i | (r_state == e_diff_empty);

  qcl_add_sub #(
    .width_p         (width_p),
    .is_add_not_sub_p(0),
    .latency_p       (0),
    .harden_p        (harden_p)
  ) u_sub (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .a_i     (data_i),
    .b_i     (w_prev_used),
    .o       (w_diff)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= e_diff_empty;
    else           r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_accept)     w_state_next = e_diff_primed;
    else if (clear_i) w_state_next = e_diff_empty;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_prev  <= '0;
      v_o     <= 1'b0;
      diff_o  <= '0;
      first_o <= 1'b0;
    end else if (w_accept) begin
      r_prev  <= data_i;
      v_o     <= 1'b1;
      diff_o  <= w_diff;
      first_o <= w_first;
    end else begin
      if (yumi_i)  v_o    <= 1'b0;
      if (clear_i) r_prev <= '0;
    end
  end

`ifdef QCL_DIFFERENTIATOR_OVF_EN
  logic w_ovf;
  assign w_ovf = sub_overflow(data_i[width_p-1], w_prev_used[width_p-1], w_diff[width_p-1]);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)     ovf_o <= 1'b0;
    else if (w_accept) ovf_o <= w_ovf;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qcl_differentiator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_qcl_differentiator: randomized and directed checks against a          |
// | running-sum reference model. Rev 1.0                                     |
// +--------------------------------------------------------------------------+
module tb_qcl_differentiator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clear;
  logic         v_in;
  logic [W-1:0] data;
  logic         yumi;
  logic         ready;
  logic         v_out;
  logic [W-1:0] diff;
  logic         first;
`ifdef QCL_DIFFERENTIATOR_OVF_EN
  logic         ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  qcl_differentiator #(.width_p(W), .harden_p(0)) dut (
    .clk_i   (clk),
    .reset_ni(reset_n),
    .clear_i (clear),
    .v_i     (v_in),
    .data_i  (data),
    .ready_o (ready),
    .v_o     (v_out),
    .diff_o  (diff),
    .first_o (first),
`ifdef QCL_DIFFERENTIATOR_OVF_EN
    .ovf_o   (ovf),
`endif
    .yumi_i  (yumi)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && yumi === 1'b1 && v_out !== 1'b1) begin
      n_fail++;
      $display("FAIL protocol: yumi_i=1 while v_o=%b", v_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    v_in = 1'b0; clear = 1'b0; yumi = v_out;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; v_in = 1'b0; yumi = 1'b0; data = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    n_tests++;
    if (v_out !== 1'b0 || diff !== '0 || first !== 1'b0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: v_o=%b diff_o=%0d first_o=%b ready_o=%b, want 0 0 0 1", v_out, diff, first, ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] s [4];
    logic [W-1:0] prev = '0;
    logic [W-1:0] e;
    s[0] = 8'd5; s[1] = 8'd12; s[2] = 8'd12; s[3] = 8'd3;
    for (int i = 0; i < 4; i++) begin
      v_in = 1'b1; data = s[i]; yumi = v_out;
      tick();
      e = W'(int'(s[i]) - int'(prev));
      prev = s[i];
      n_tests++;
      if (v_out !== 1'b1 || diff !== e || first !== (i == 0)) begin
        n_fail++;
        $display("FAIL basic[%0d]: v_o=%b diff_o=%0d first_o=%b, want 1 %0d %b", i, v_out, diff, first, e, i == 0);
      end
    end
    v_in = 1'b0; yumi = 1'b1;
    tick();
    n_tests++;
    if (v_out !== 1'b0) begin
      n_fail++;
      $display("FAIL basic drain: v_o=%b want 0", v_out);
    end
  endtask

  // Previous accepted sample on entry is 3.
  task automatic test_backpressure();
    v_in = 1'b1; data = 8'd40; yumi = 1'b0;
    tick();
    n_tests++;
    if (v_out !== 1'b1 || diff !== 8'd37) begin
      n_fail++;
      $display("FAIL bp first: v_o=%b diff_o=%0d want 1 37", v_out, diff);
    end
    data = 8'd50;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (ready !== 1'b0 || v_out !== 1'b1 || diff !== 8'd37) begin
        n_fail++;
        $display("FAIL bp hold[%0d]: ready_o=%b v_o=%b diff_o=%0d want 0 1 37", i, ready, v_out, diff);
      end
      tick();
    end
    yumi = 1'b1;
    tick();
    n_tests++;
    if (v_out !== 1'b1 || diff !== 8'd10 || first !== 1'b0) begin
      n_fail++;
      $display("FAIL bp release: v_o=%b diff_o=%0d first_o=%b want 1 10 0", v_out, diff, first);
    end
    v_in = 1'b0; yumi = 1'b1;
    tick();
    n_tests++;
    if (v_out !== 1'b0) begin
      n_fail++;
      $display("FAIL bp duplicate: v_o=%b want 0", v_out);
    end
  endtask

  // Previous accepted sample on entry is 50.
  task automatic test_clear();
    v_in = 1'b1; data = 8'd100; yumi = 1'b0;
    tick();
    v_in = 1'b0; clear = 1'b1; yumi = 1'b0;
    tick();
    n_tests++;
    if (v_out !== 1'b1 || diff !== 8'd50 || first !== 1'b0) begin
      n_fail++;
      $display("FAIL clear keeps pending: v_o=%b diff_o=%0d first_o=%b want 1 50 0", v_out, diff, first);
    end
    clear = 1'b0; v_in = 1'b1; data = 8'd7; yumi = 1'b1;
    tick();
    n_tests++;
    if (diff !== 8'd7 || first !== 1'b1) begin
      n_fail++;
      $display("FAIL clear alone: diff_o=%0d first_o=%b want 7 1", diff, first);
    end
    data = 8'd100;
    tick();
    clear = 1'b1; data = 8'd30;
    tick();
    n_tests++;
    if (diff !== 8'd30 || first !== 1'b1) begin
      n_fail++;
      $display("FAIL clear+accept: diff_o=%0d first_o=%b want 30 1", diff, first);
    end
    clear = 1'b0; data = 8'd35;
    tick();
    n_tests++;
    if (diff !== 8'd5 || first !== 1'b0) begin
      n_fail++;
      $display("FAIL after clear: diff_o=%0d first_o=%b want 5 0", diff, first);
    end
    idle();
  endtask

  task automatic test_async_reset();
    v_in = 1'b1; data = 8'd77; yumi = v_out;
    tick();
    v_in = 1'b0; yumi = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (v_out !== 1'b0 || first !== 1'b0) begin
      n_fail++;
      $display("FAIL async reset: v_o=%b first_o=%b want 0 0", v_out, first);
    end
    tick();
    reset_n = 1'b1;
    v_in = 1'b1; data = 8'd9;
    tick();
    n_tests++;
    if (v_out !== 1'b1 || diff !== 8'd9 || first !== 1'b1) begin
      n_fail++;
      $display("FAIL post reset: v_o=%b diff_o=%0d first_o=%b want 1 9 1", v_out, diff, first);
    end
    idle();
  endtask

  task automatic test_loopback();
    logic [W-1:0] samples [200];
    logic [W-1:0] exp_q [$];
    bit           first_q [$];
    logic [W-1:0] acc = '0;
    logic [W-1:0] e;
    bit           f;
    int sent = 0, got = 0, cyc = 0;
    for (int i = 0; i < 200; i++) samples[i] = W'($urandom);
    clear = 1'b1; v_in = 1'b0; yumi = v_out;
    tick();
    clear = 1'b0;
    while (got < 200 && cyc < 3000) begin
      v_in = (sent < 200) && ($urandom_range(3) != 0);
      data = v_in ? W'(acc + samples[sent]) : W'($urandom);
      yumi = v_out && ($urandom_range(1) == 1);
      #1;
      if (ready !== (!v_out || yumi)) begin
        n_tests++; n_fail++;
        $display("FAIL loop ready: ready_o=%b v_o=%b yumi_i=%b", ready, v_out, yumi);
      end
      if (yumi) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL loop extra: diff_o=%0d with no sample outstanding", diff);
        end else begin
          e = exp_q.pop_front();
          f = first_q.pop_front();
          if (diff !== e || first !== f) begin
            n_fail++;
            $display("FAIL loop[%0d]: diff_o=%0d first_o=%b want %0d %b", got, diff, first, e, f);
          end
        end
        got++;
      end
      if (v_in && ready) begin
        acc = W'(acc + samples[sent]);
        exp_q.push_back(samples[sent]);
        first_q.push_back(sent == 0);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    n_tests++;
    if (got != 200) begin
      n_fail++;
      $display("FAIL loop count: got %0d outputs want 200", got);
    end
    idle();
  endtask

`ifdef QCL_DIFFERENTIATOR_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] s [4];
    logic [W-1:0] prev = '0;
    int sd;
    bit eo;
    s[0] = 8'h80; s[1] = 8'h7F; s[2] = 8'h10; s[3] = 8'h20;
    clear = 1'b1; v_in = 1'b0; yumi = v_out;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v_in = 1'b1; data = s[i]; yumi = v_out;
      tick();
      sd = int'($signed(s[i])) - int'($signed(prev));
      eo = (sd > 127) || (sd < -128);
      n_tests++;
      if (diff !== W'(sd) || ovf !== eo) begin
        n_fail++;
        $display("FAIL ovf[%0d]: diff_o=%0h ovf_o=%b want %0h %b", i, diff, ovf, W'(sd), eo);
      end
      prev = s[i];
    end
    idle();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_loopback();
`ifdef QCL_DIFFERENTIATOR_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qcl_differentiator.md
Name: qcl_differentiator

Overview:
- Streaming first-difference block: out[n] = in[n] - in[n-1] (mod 2^width_p), with in[-1] = 0 after reset or clear.
- Exact inverse of the team's running-sum accumulator. Feeding accumulator sum outputs in order recovers the original samples.
- Sits on decode/readback paths that carry accumulated counts or phases.
- Output side is one registered stage with valid/yumi flow control.

Parameters:
- width_p, "inv": data and difference width in bits; must be >= 1.
- harden_p, 0: passed through to the subtractor instance.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous restart: previous sample forced to 0, state to EMPTY
- v_i  in  1  input sample valid
- data_i  in  width_p  input sample (accumulated value)
- ready_o  out  1  block can accept data_i this cycle
- v_o  out  1  diff_o holds a valid result
- diff_o  out  width_p  data_i - previous accepted sample, modulo 2^width_p
- first_o  out  1  result is the first sample since reset/clear (prev used was 0)
- yumi_i  in  1  consumer takes diff_o this cycle; legal only when v_o=1

Behaviour:
- Reset (reset_ni=0, async assert, sync deassert handled by the integrator):
  - prev_r=0, state=EMPTY, v_o=0, diff_o=0, first_o=0.
- Accept rule:
  - ready_o = ~v_o | yumi_i (combinational; no dependency on v_i).
  - A sample is accepted when v_i & ready_o.
- Latency: 1 cycle. An accepted sample appears on diff_o/v_o the next cycle.
  - Full throughput while yumi_i is held high.
- On accept:
  - diff_o <= data_i - prev_r (width_p-bit wraparound, no carry out).
  - prev_r <= data_i; v_o <= 1.
  - first_o <= (state==EMPTY); state <= PRIMED.
- No accept and yumi_i=1: v_o <= 0. diff_o and first_o hold their stale values and are don't-care.
- No accept and yumi_i=0: output registers hold. Backpressure is lossless.
- State machine:
  - EMPTY -> PRIMED on accept.
  - PRIMED -> EMPTY on clear_i.
  - Reset goes to EMPTY.
- clear_i rules:
  - Does not touch a pending output. v_o, diff_o and first_o are preserved.
  - Same cycle as an accept: the accepted sample uses prev=0 and first_o=1; prev_r <= data_i; state <= PRIMED.
  - Clear without accept: prev_r <= 0; state <= EMPTY.
- Wraparound examples (width 8): prev=250, in=4 -> diff=10. in == prev -> diff=0.
- yumi_i while v_o=0 is a protocol error; the bench asserts it never happens. The RTL ignores it.
- Reset mid-stream: the pending output is discarded, v_o drops immediately, and the next sample is treated as first.

Optional Feature:
- Macro: QCL_DIFFERENTIATOR_OVF_EN.
- With the macro defined:
  - Adds output port ovf_o (1 bit), registered alongside diff_o.
  - ovf_o=1 when the two's-complement signed subtraction data_i - prev overflowed, i.e. the operand signs differ and the result sign differs from data_i.
  - ovf_o resets to 0 and holds under backpressure like diff_o.
- Without the macro: the port is absent and no overflow logic is built.

Decomposition:
- Package qcl_differentiator_pkg: state enum (e_diff_empty, e_diff_primed), 1 bit.
- Subtraction: reuse existing qcl_add_sub with is_add_not_sub_p=0, latency_p=0, harden_p passed through.
- Output stage and prev register inline; no further sub-module.

Test Plan:
- Reset then inputs 5, 12, 12, 3 (width 8), yumi_i=1 -> diff_o 5, 7, 0, 247, one per cycle; first_o=1 on the first result only.
- Accumulator loopback: random 200 samples -> accumulator -> differentiator -> output sequence equals the original samples, with yumi_i toggled randomly.
- Backpressure: yumi_i=0 for 4 cycles with v_i=1 -> ready_o=0 after the first accept; diff_o stable; no sample lost or duplicated after release.
- Clear with accept: prev=100, clear_i=1 with data_i=30 -> diff_o=30, first_o=1; next input 35 -> diff_o=5, first_o=0.
- Async reset mid-stream with v_o=1 -> v_o=0 immediately; next input 9 -> diff_o=9, first_o=1.
- With QCL_DIFFERENTIATOR_OVF_EN, width 8: prev=0x80, in=0x7F -> diff_o=0xFF, ovf_o=1; prev=0x10, in=0x20 -> diff_o=0x10, ovf_o=0.
